// File: rtl/dsp48a1_mac_seq_pkg.sv
// Shared types and DSP48A1 OPMODE constants for the MAC sequencer.
package dsp48a1_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [7:0] OPMODE_P_EQ_M  = 8'h01;
   localparam logic [7:0] OPMODE_P_ACC_M = 8'h09;
   localparam logic [7:0] OPMODE_IDLE    = 8'h00;

   // OPMODE for the token currently sitting in front of the P register.
   function automatic logic [7:0] opmode_sel(input logic valid, input logic first);
      if (!valid)
         return OPMODE_IDLE;
      else if (first)
         return OPMODE_P_EQ_M;
      else
         return OPMODE_P_ACC_M;
   endfunction

endpackage

// File: rtl/dsp48a1_mac_seq_if.sv
// Operand stream (valid/ready) between the operand source and the sequencer.
interface dsp48a1_mac_seq_if #(
   parameter int WIDTH = 18
) ();
   logic signed [WIDTH-1:0] a_in;
   logic signed [WIDTH-1:0] b_in;
   logic                    in_valid;
   logic                    in_ready;

   modport master (output a_in, output b_in, output in_valid, input in_ready);
   modport slave  (input a_in, input b_in, input in_valid, output in_ready);
endinterface

// File: rtl/dsp48a1_mac_seq_tok_pipe.sv
// Two-stage {valid, first} token shift register tracking operands through M and P.
module mac_tok_pipe (
   input  logic clk,
   input  logic rst,
   input  logic tok_valid,
   input  logic tok_first,
   output logic ce_m,
   output logic ce_p,
   output logic first_p
);

   logic s0_valid, s0_first;
   logic s1_valid, s1_first;

   // Shift tokens one stage per cycle; bubbles travel as invalid tokens.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_first <= 1'b0;
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
      end else begin
         s0_valid <= tok_valid;
         s0_first <= tok_first;
         s1_valid <= s0_valid;
         s1_first <= s0_first;
      end
   end

   assign ce_m    = s0_valid;
   assign ce_p    = s1_valid;
   assign first_p = s1_first;

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// Sequencer driving a DSP48A1 slice (AREG/BREG, MREG, PREG on) as a signed MAC.
module dsp48a1_mac_seq
   import dsp48a1_pkg::*;
#(
   parameter int WIDTH = 18,
   parameter int LEN_W = 8,
   parameter int P_W   = 48
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [LEN_W-1:0]       len,
   output logic                   busy,
   dsp48a1_mac_seq_if.slave       op,
   output logic [WIDTH-1:0]       dsp_a,
   output logic [WIDTH-1:0]       dsp_b,
   output logic                   ce_ab,
   output logic                   ce_m,
   output logic                   ce_p,
   output logic [7:0]             opmode,
   input  logic [P_W-1:0]         p_in,
   output logic [P_W-1:0]         result,
   output logic                   result_valid
);

   state_t           state, state_nx;
   logic [LEN_W-1:0] remaining;
   logic             first_q;
   logic             zero_pend;
   logic             hs;
   logic             capture;
   logic             first_p;

   assign dsp_a  = op.a_in;
   assign dsp_b  = op.b_in;
   assign hs     = op.in_valid & op.in_ready;
   assign ce_ab  = hs;
   assign opmode = opmode_sel(ce_p, first_p);

   mac_tok_pipe u_tok_pipe (
      .clk       (clk),
      .rst       (rst),
      .tok_valid (hs),
      .tok_first (first_q),
      .ce_m      (ce_m),
      .ce_p      (ce_p),
      .first_p   (first_p)
   );

   // Next-state, ready, busy and result pulse decode.
   // A zero-length command spends one DONE cycle clearing result (zero_pend)
   // so the pulse lands two cycles after start with result already 0.
   always_comb begin
      state_nx     = state;
      op.in_ready  = 1'b0;
      busy         = 1'b0;
      result_valid = 1'b0;
      capture      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start)
               state_nx = (len == '0) ? ST_DONE : ST_LOAD;
         end
         ST_LOAD: begin
            busy        = 1'b1;
            op.in_ready = (remaining != '0);
            if (hs && remaining == LEN_W'(1))
               state_nx = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            // Pipe empty means the last P write landed last cycle: p_in is final.
            if (!ce_m && !ce_p) begin
               capture  = 1'b1;
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            if (zero_pend) begin
               busy = 1'b1;
            end else begin
               result_valid = 1'b1;
               state_nx     = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State, pair counter, first-token flag and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         first_q   <= 1'b0;
         zero_pend <= 1'b0;
         result    <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && start) begin
            remaining <= len;
            first_q   <= 1'b1;
            zero_pend <= (len == '0);
         end else if (hs) begin
            remaining <= remaining - LEN_W'(1);
            first_q   <= 1'b0;
         end
         if (capture)
            result <= p_in;
         if (state == ST_DONE && zero_pend) begin
            result    <= '0;
            zero_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Scoreboard bench for dsp48a1_mac_seq driving a behavioural DSP48A1 slice model.
module tb_dsp48a1_mac_seq;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [7:0]         len;
   logic               busy;
   logic signed [17:0] dsp_a, dsp_b;
   logic               ce_ab, ce_m, ce_p;
   logic [7:0]         opmode;
   logic [47:0]        p_in;
   logic [47:0]        result;
   logic               result_valid;

   dsp48a1_mac_seq_if #(.WIDTH(18)) op ();

   dsp48a1_mac_seq #(.WIDTH(18), .LEN_W(8), .P_W(48)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .len          (len),
      .busy         (busy),
      .op           (op.slave),
      .dsp_a        (dsp_a),
      .dsp_b        (dsp_b),
      .ce_ab        (ce_ab),
      .ce_m         (ce_m),
      .ce_p         (ce_p),
      .opmode       (opmode),
      .p_in         (p_in),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   // Behavioural DSP48A1 slice: A/B, M, P registers with clock enables.
   logic signed [17:0] a_r, b_r;
   logic signed [35:0] m_r;
   logic signed [47:0] p_r;
   always @(posedge clk) begin
      if (ce_ab) begin
         a_r <= dsp_a;
         b_r <= dsp_b;
      end
      if (ce_m)
         m_r <= a_r * b_r;
      if (ce_p) begin
         case (opmode)
            8'h01:   p_r <= {{12{m_r[35]}}, m_r};
            8'h09:   p_r <= p_r + {{12{m_r[35]}}, m_r};
            default: p_r <= p_r;
         endcase
      end
   end
   assign p_in = p_r;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct {
      longint val;
      int     start;
      int     lat;
   } exp_t;
   exp_t sb[$];

   int cep_cnt, hs_cnt, rdy_cnt, done_cnt = 0;

   // Monitor: count enables/handshakes and score each result pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (ce_p) cep_cnt++;
         if (op.in_valid && op.in_ready) hs_cnt++;
         if (op.in_ready) rdy_cnt++;
         if (result_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_result_valid", longint'(result_valid), 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", longint'($signed(result)), e.val);
               if (e.lat >= 0) chk("latency", cyc - e.start, e.lat);
               chk("busy_at_result", longint'(busy), 0);
            end
            done_cnt++;
         end
      end
   end

   logic signed [17:0] a_arr[256];
   logic signed [17:0] b_arr[256];

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_in_ready"},     longint'(op.in_ready), 0);
      chk({pfx, "_busy"},         longint'(busy), 0);
      chk({pfx, "_ce_ab"},        longint'(ce_ab), 0);
      chk({pfx, "_ce_m"},         longint'(ce_m), 0);
      chk({pfx, "_ce_p"},         longint'(ce_p), 0);
      chk({pfx, "_opmode"},       longint'(opmode), 0);
      chk({pfx, "_result"},       longint'(result), 0);
      chk({pfx, "_result_valid"}, longint'(result_valid), 0);
   endtask

   // Issue one command of n pairs with bub idle cycles between pairs;
   // inj pulses a stray start (len=7) alongside the second pair.
   task automatic run(input int n, input int bub, input bit inj);
      exp_t   e;
      longint acc;
      int     d0, t;
      acc = 0;
      for (int i = 0; i < n; i++) acc += longint'(a_arr[i]) * longint'(b_arr[i]);
      cep_cnt = 0; hs_cnt = 0; rdy_cnt = 0; d0 = done_cnt;
      start   = 1'b1;
      len     = n[7:0];
      e.val   = acc;
      e.start = cyc;
      e.lat   = (bub != 0) ? -1 : ((n == 0) ? 2 : n + 4);
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", longint'(busy), 1);
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            for (int k = 0; k < bub; k++) begin
               op.in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         op.in_valid = 1'b1;
         op.a_in     = a_arr[i];
         op.b_in     = b_arr[i];
         if (inj && i == 1) begin
            start = 1'b1;
            len   = 8'd7;
         end
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!op.in_ready && t < 50);
         if (!op.in_ready) chk("in_ready_timeout", longint'(op.in_ready), 1);
         @(posedge clk); #1;
         start = 1'b0;
      end
      op.in_valid = 1'b0;
      t = 0;
      while (done_cnt == d0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("result_pulses", done_cnt - d0, 1);
      chk("ce_p_count", cep_cnt, n);
      chk("handshake_count", hs_cnt, n);
      if (n == 0) chk("in_ready_zero_len", rdy_cnt, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0;
      op.in_valid = 1'b0; op.a_in = '0; op.b_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic dot product
      a_arr[0] = 2;  b_arr[0] = 3;
      a_arr[1] = 4;  b_arr[1] = 5;
      a_arr[2] = -1; b_arr[2] = 7;
      run(3, 0, 1'b0);

      // Same data with two-cycle bubbles
      run(3, 2, 1'b0);

      // Zero length
      run(0, 0, 1'b0);

      // Stray start during LOAD is ignored
      a_arr[0] = 5;  b_arr[0] = -6;
      a_arr[1] = 7;  b_arr[1] = 8;
      a_arr[2] = -9; b_arr[2] = -10;
      a_arr[3] = 3;  b_arr[3] = 3;
      run(4, 0, 1'b1);

      // Asynchronous reset in the middle of LOAD
      start = 1'b1; len = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
      op.in_valid = 1'b1; op.a_in = 18'sd100; op.b_in = 18'sd200;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("mid_reset");
      op.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      a_arr[0] = -131072; b_arr[0] = -131072;
      a_arr[1] = 1;       b_arr[1] = 1;
      run(2, 0, 1'b0);

      // Full-scale length, largest positive operands
      for (int i = 0; i < 255; i++) begin
         a_arr[i] = 131071;
         b_arr[i] = 131071;
      end
      run(255, 0, 1'b0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
